// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and FSM encoding for the input fetcher
package fetch_pkg;
   localparam int ADDR_WIDTH_DEF = 12;
   localparam int DATA_WIDTH_DEF = 16;
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;
endpackage

// File: rtl/input_fetcher_if.sv
// input_fetcher_if: valid/ready output stream of the input fetcher
interface input_fetcher_if #(parameter int DATA_WIDTH = fetch_pkg::DATA_WIDTH_DEF);
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   modport master (output out_valid, output out_data, output out_last, input out_ready);
   modport slave (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO holding fetched words with their last flag
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 17,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;
   assign full     = count_q == CW'(DEPTH);
   assign empty    = count_q == '0;
   assign count    = count_q;
   assign pop_data = empty ? '0 : mem_q[rd_q];
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;
   // pointer wrap and occupancy update; push and pop together keep the count
   always_comb begin
      mem_d = mem_q;
      if (push_ok) mem_d[wr_q] = push_data;
      wr_d    = push_ok ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
      rd_d    = pop_ok ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end
   // storage and pointer registers, cleared by reset so the output reads zero
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         mem_q   <= '{default: '0};
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/input_fetcher.sv
// input_fetcher: streams a run of consecutive SRAM words out over valid/ready
module input_fetcher
   import fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset_b,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] word_count,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] dut_sram_read_address,
   input  logic [DATA_WIDTH-1:0] sram_dut_read_data,
   input_fetcher_if.master       out_if
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, left_q, left_d;
   logic                  issue, issue_q, last_q, last_d;
   logic                  pop, full, empty;
   logic [CW-1:0]         count;
   logic [CW:0]           occ;
   assign pop                   = out_if.out_valid & out_if.out_ready;
   assign out_if.out_valid      = ~empty;
   assign busy                  = (state_q == FETCH) | (state_q == DRAIN);
   assign done                  = state_q == DONE;
   assign dut_sram_read_address = addr_q;
   assign occ                   = {1'b0, count} + {{CW{1'b0}}, issue_q} - {{CW{1'b0}}, pop};
   // sequencing: a read is issued only when its word is guaranteed a FIFO slot
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      left_d  = left_q;
      issue   = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = (word_count == '0) ? DONE : FETCH;
            addr_d  = (word_count == '0) ? '0 : base_addr;
            left_d  = word_count;
         end
         FETCH: begin
            issue = (occ < (CW + 1)'(FIFO_DEPTH)) & ~(full & ~pop);
            if (issue) begin
               left_d  = left_q - 1'b1;
               state_d = (left_q == ADDR_WIDTH'(1)) ? DRAIN : FETCH;
               addr_d  = (left_q == ADDR_WIDTH'(1)) ? addr_q : addr_q + 1'b1;
            end
         end
         DRAIN: state_d = (pop & out_if.out_last) ? DONE : DRAIN;
         default: begin
            state_d = IDLE;
            addr_d  = '0;
         end
      endcase
      last_d = issue & (left_q == ADDR_WIDTH'(1));
   end
   // state, address and read-pipeline registers
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q <= IDLE;
         addr_q  <= '0;
         left_q  <= '0;
         issue_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         left_q  <= left_d;
         issue_q <= issue;
         last_q  <= last_d;
      end
   end
   fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH + 1)) u_fifo (
      .clk       (clk),
      .reset_b   (reset_b),
      .push      (issue_q),
      .push_data ({last_q, sram_dut_read_data}),
      .pop       (pop),
      .pop_data  ({out_if.out_last, out_if.out_data}),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );
endmodule

// File: doc/input_fetcher.md
INPUT_FETCHER -- requirements
Module: input_fetcher

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_WIDTH, 12, SRAM address width.
- DATA_WIDTH, 16, SRAM word width.
- FIFO_DEPTH, 2, output buffer entries; minimum 2.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all state rises on posedge.
- reset_b, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request to begin a fetch.
- base_addr, in, ADDR_WIDTH, first word address; sampled with start.
- word_count, in, ADDR_WIDTH, number of words to fetch; sampled with start.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle completion pulse.
- dut_sram_read_address, out, ADDR_WIDTH, input SRAM read address.
- sram_dut_read_data, in, DATA_WIDTH, input SRAM read data; valid exactly 1 cycle after the address is presented.
- out_valid, out, 1, out_data holds a word.
- out_ready, in, 1, consumer accepts the word.
- out_data, out, DATA_WIDTH, fetched word.
- out_last, out, 1, qualifies the final word of the fetch.

Function
REQ-003 Upstream stage of the compute core: the block SHALL stream word_count consecutive input-SRAM words, starting at base_addr, over a valid/ready interface in address order.
REQ-004 FSM states SHALL be IDLE, FETCH, DRAIN, DONE.
- IDLE -> FETCH on start with word_count != 0.
- IDLE -> DONE on start with word_count == 0.
- FETCH -> DRAIN once the last read has been issued.
- DRAIN -> DONE on the last-word handshake (out_valid & out_ready & out_last).
- DONE -> IDLE after exactly one cycle.
REQ-005 start SHALL be ignored in every state except IDLE.
REQ-006 In FETCH, a read SHALL be issued in a cycle only if reads in flight + FIFO occupancy < FIFO_DEPTH; otherwise the address holds.
REQ-007 Each issued read SHALL push sram_dut_read_data into the FIFO exactly one cycle later, unconditionally.
REQ-008 Address SHALL increment by 1 per issued read, modulo 2^ADDR_WIDTH (0xFFF wraps to 0x000).
REQ-009 dut_sram_read_address SHALL hold its last value when no read is issued and SHALL be 0 in IDLE.
REQ-010 A handshake SHALL occur iff out_valid & out_ready in the same cycle.
REQ-011 out_data and out_last SHALL remain stable while out_valid is high and out_ready is low.
REQ-012 A push and a pop in the same cycle SHALL leave occupancy unchanged and lose no data.
REQ-013 With out_ready held high, the block SHALL sustain 1 word/cycle; the first out_valid SHALL appear 3 cycles after the start cycle.
REQ-014 done SHALL pulse in the DONE state; busy SHALL be low in IDLE and DONE.
REQ-015 A word_count == 0 request SHALL produce no reads, no out_valid, and done 1 cycle after start.

Reset
REQ-016 While reset_b is low, the block SHALL force the following, independent of clk:
- State = IDLE.
- busy = 0, done = 0, out_valid = 0, out_last = 0.
- out_data = 0, dut_sram_read_address = 0.
- FIFO empty, counters cleared.
REQ-017 Reset asserted mid-fetch SHALL abort the fetch silently (no done pulse); a start after reset release SHALL run normally.

Structure
REQ-018 A shared package fetch_pkg SHALL hold:
- ADDR_WIDTH and DATA_WIDTH defaults.
- The FSM state enum.
REQ-019 The output buffer SHALL be one sub-module, fetch_fifo:
- Parameterised synchronous FIFO with push, pop, full, empty, and a count output.
- out_last stored alongside each data word.

Verification
REQ-020 Basic stream: base_addr = 0x010, word_count = 4, out_ready = 1 -> data from mem[0x010..0x013] in order, out_last on the 4th word, done 1 cycle after that handshake.
REQ-021 Backpressure: word_count = 8, out_ready toggling 1/0 each cycle -> all 8 words delivered in order, with no duplicates, no drops, and stable data while stalled.
REQ-022 Wrap: base_addr = 0xFFE, word_count = 4 -> addresses issued are 0xFFE, 0xFFF, 0x000, 0x001.
REQ-023 Zero count: word_count = 0 -> no out_valid, done 1 cycle after start, busy never high.
REQ-024 Reset mid-fetch: reset_b low during word 3 of 10 -> all outputs 0 immediately, no done pulse; a subsequent start with word_count = 2 completes correctly.
REQ-025 start while busy: a second start during a fetch of 6 words -> ignored; exactly 6 words and one done pulse.
